// File: rtl/flash_bank.sv
// flash_bank
//   Sixteen-entry record store that sits behind the password-manager core.
//   Each record is DW bits: [255:128] encrypted account, [127:0] encrypted
//   password. The core reads through add_flash (registered, one-cycle
//   latency), writes/append records with flash_write, and sees the highest
//   valid address on max_address. A host-driven wipe zeroes the whole
//   array one entry per cycle.
//
//   Optional feature macro: FLASH_PARITY_EN
//     defined   : one even-parity bit stored per entry, checked on every read
//                 and reported on par_err alongside data_flash.
//     undefined : no parity storage, par_err tied low.
//
// Ports
//   clk              in   clock, rising edge
//   rst              in   asynchronous active-low reset
//   add_flash        in   read/write address
//   flash_write      in   write strobe, one cycle per record
//   write_data_flash in   record to store
//   data_flash       out  registered read data for add_flash
//   max_address      out  entry_count-1 (0 when empty)
//   empty / full     out  occupancy flags
//   wr_err           out  one-cycle pulse after a rejected write
//   wipe             in   host erase request
//   busy             out  wipe in progress
//   par_err          out  parity mismatch on the last read
//
// state | meaning
// IDLE  | serve reads/writes, accept a wipe request
// WIPE  | clear array[wipe_ptr] each cycle, 0..DEPTH-1
// DONE  | clear entry count, drop busy, back to IDLE
module flash_bank #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] add_flash,
  input  logic          flash_write,
  input  logic [DW-1:0] write_data_flash,
  output logic [DW-1:0] data_flash,
  output logic [AW-1:0] max_address,
  output logic          empty,
  output logic          full,
  output logic          wr_err,
  input  logic          wipe,
  output logic          busy,
  output logic          par_err
);

  typedef enum logic [1:0] {IDLE, WIPE, DONE} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   entry_count;
  logic [AW-1:0] wipe_ptr;
  // A wipe only starts once wipe has been seen low in IDLE, so a request
  // held high through DONE does not immediately start another pass.
  logic          wipe_arm;
  logic          start_wipe;
  logic [AW:0]   add_ext;

`ifdef FLASH_PARITY_EN
  logic          par_mem [DEPTH];
`endif

  assign add_ext    = {1'b0, add_flash};
  assign start_wipe = (state == IDLE) && wipe && wipe_arm;

  assign empty       = (entry_count == '0);
  assign full        = (entry_count == (AW+1)'(DEPTH));
  assign max_address = empty ? '0 : AW'(entry_count - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      entry_count <= '0;
      wipe_ptr    <= '0;
      wipe_arm    <= 1'b1;
      busy        <= 1'b0;
      wr_err      <= 1'b0;
      data_flash  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef FLASH_PARITY_EN
      par_err     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
`endif
    end else begin
      // Reads run in every state; a same-cycle write is seen next cycle.
      data_flash <= mem[add_flash];
`ifdef FLASH_PARITY_EN
      par_err    <= par_mem[add_flash] ^ (^mem[add_flash]);
`endif
      wr_err     <= 1'b0;

      case (state)
        IDLE: begin
          if (start_wipe) begin
            state    <= WIPE;
            wipe_ptr <= '0;
            busy     <= 1'b1;
            wipe_arm <= 1'b0;
          end else begin
            if (!wipe) wipe_arm <= 1'b1;
            if (flash_write) begin
              if (add_ext < entry_count) begin
                mem[add_flash] <= write_data_flash;
`ifdef FLASH_PARITY_EN
                par_mem[add_flash] <= ^write_data_flash;
`endif
              end else if ((add_ext == entry_count) && !full) begin
                mem[add_flash] <= write_data_flash;
`ifdef FLASH_PARITY_EN
                par_mem[add_flash] <= ^write_data_flash;
`endif
                entry_count <= entry_count + 1'b1;
              end else begin
                wr_err <= 1'b1;
              end
            end
          end
        end

        WIPE: begin
          mem[wipe_ptr] <= '0;
`ifdef FLASH_PARITY_EN
          par_mem[wipe_ptr] <= 1'b0;
`endif
          wipe_ptr <= wipe_ptr + 1'b1;
          if (wipe_ptr == AW'(DEPTH - 1)) state <= DONE;
        end

        DONE: begin
          entry_count <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef FLASH_PARITY_EN
  assign par_err = 1'b0;
`endif

endmodule
